int8_word_packer: RTL and testbench

//  Output stage directly downstream of the INT32->INT8 requantizer. Collects signed INT8

---
 rtl/dpu_pkg.sv | 15 +
 rtl/dpu_sync_fifo.sv | 54 +++++
 rtl/int8_word_packer.sv | 101 ++++++++++
 tb/tb_int8_word_packer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpu_pkg.sv
// rtl/dpu_pkg.sv - shared types for the DPU output path
package dpu_pkg;

  typedef logic signed [7:0] int8_t;

  localparam int DPU_OUT_LANES = 4;

  // Packed-word FIFO entry; field order matches the flat entry used by the packer.
  typedef struct packed {
    logic [8*DPU_OUT_LANES-1:0] data;
    logic [DPU_OUT_LANES-1:0]   mask;
    logic                       last;
  } dpu_word_t;

endpackage

// File: rtl/dpu_sync_fifo.sv
// rtl/dpu_sync_fifo.sv - first-word-fall-through synchronous FIFO with level output
module dpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = LVL_W'(wr_ptr - rd_ptr);

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Head is forced to zero when empty so stale storage never shows on the outputs.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/int8_word_packer.sv
// rtl/int8_word_packer.sv - packs INT8 samples little-endian into words and queues them for DMA
module int8_word_packer
  import dpu_pkg::*;
#(
  parameter int LANES      = DPU_OUT_LANES,
  parameter int FIFO_DEPTH = 4,
  localparam int WORD_W    = 8 * LANES,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  int8_t             in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [LANES-1:0]  out_mask,
  output logic              out_last,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              err_overflow
);

  localparam int ENTRY_W = WORD_W + LANES + 1;
  localparam int PTR_W   = $clog2(LANES);

  logic [PTR_W-1:0]   lane_ptr;
  logic [WORD_W-1:0]  asm_data;
  logic [LANES-1:0]   asm_mask;
  logic [WORD_W-1:0]  word_data;
  logic [LANES-1:0]   word_mask;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               close;
  logic               pop;

  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready && !clear;
  assign close    = accept && (in_last || (lane_ptr == PTR_W'(LANES - 1)));
  assign pop      = out_valid && out_ready && !clear;

  // Assembly register with the incoming sample merged into its lane.
  always_comb begin
    word_data = asm_data;
    word_mask = asm_mask;
    word_data[lane_ptr*8 +: 8] = in_data;
    word_mask[lane_ptr]        = 1'b1;
  end

  assign push_entry = {word_data, word_mask, in_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_ptr     <= '0;
      asm_data     <= '0;
      asm_mask     <= '0;
      err_overflow <= 1'b0;
    end else if (clear) begin
      lane_ptr     <= '0;
      asm_data     <= '0;
      asm_mask     <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (in_valid && !in_ready) err_overflow <= 1'b1;
      if (close) begin
        lane_ptr <= '0;
        asm_data <= '0;
        asm_mask <= '0;
      end else if (accept) begin
        lane_ptr <= lane_ptr + PTR_W'(1);
        asm_data <= word_data;
        asm_mask <= word_mask;
      end
    end
  end

  dpu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (close),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign {out_data, out_mask, out_last} = head_entry;

endmodule

// File: tb/tb_int8_word_packer.sv
// tb/tb_int8_word_packer.sv - self-checking bench for int8_word_packer
module tb_int8_word_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_mask;
  logic        out_last;
  logic [2:0]  fifo_level;
  logic        err_overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int8_word_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_mask     (out_mask),
    .out_last     (out_last),
    .fifo_level   (fifo_level),
    .err_overflow (err_overflow)
  );

  // Reference model: a list of pending bytes and a queue of finished words.
  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    logic        last;
  } mword_t;

  logic [7:0] part[$];
  mword_t     mq[$];
  bit         merr;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        ordy;
    logic        ov;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        last;
    int          lvl;
    logic        rdy;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    part.delete();
    mq.delete();
    merr = 1'b0;
  endtask

  task automatic model_check();
    chk("in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 4});
    chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
    chk("fifo_level", {61'd0, fifo_level}, 64'(mq.size()));
    chk("err_overflow", {63'd0, err_overflow}, {63'd0, merr});
    if (mq.size() > 0) begin
      chk("out_data", {32'd0, out_data}, {32'd0, mq[0].data});
      chk("out_mask", {60'd0, out_mask}, {60'd0, mq[0].mask});
      chk("out_last", {63'd0, out_last}, {63'd0, mq[0].last});
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic l,
                            input logic ordy, input logic clr);
    bit     rdy;
    mword_t w;
    if (clr) begin
      model_reset();
      return;
    end
    rdy = (mq.size() < 4);
    if (mq.size() > 0 && ordy) void'(mq.pop_front());
    if (v && !rdy) merr = 1'b1;
    if (v && rdy) begin
      part.push_back(d);
      if (part.size() == 4 || l) begin
        w.data = 32'd0;
        w.mask = 4'd0;
        w.last = l;
        for (int i = 0; i < part.size(); i++) begin
          w.data = w.data | (32'(part[i]) << (8 * i));
          w.mask[i] = 1'b1;
        end
        mq.push_back(w);
        part.delete();
      end
    end
  endtask

  // One clock: drive, check pre-edge outputs against the model, clock, advance the model.
  task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                     input logic ordy, input logic clr);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    clear     = clr;
    model_check();
    @(posedge clk);
    model_step(v, d, l, ordy, clr);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_reset();

    tbl[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 0, 1'b1};
    tbl[1] = '{1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 0, 1'b1};
    tbl[2] = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 0, 1'b1};
    tbl[3] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 32'hFF807F01, 4'hF, 1'b0, 1, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 0, 1'b1};
    tbl[5] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 0, 1'b1};
    tbl[6] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 32'h00002211, 4'h3, 1'b1, 1, 1'b1};
    tbl[7] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 32'h00000033, 4'h1, 1'b1, 1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 0, 1'b1};

    #2;
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst fifo_level", {61'd0, fifo_level}, 64'd0);
    chk("rst err", {63'd0, err_overflow}, 64'd0);
    chk("rst out_data", {32'd0, out_data}, 64'd0);
    chk("rst out_mask", {60'd0, out_mask}, 64'd0);
    chk("rst out_last", {63'd0, out_last}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full word, partial word with last, fresh start after last.
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy, 1'b0);
      chk($sformatf("tbl%0d out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].ov});
      chk($sformatf("tbl%0d level", i), {61'd0, fifo_level}, 64'(tbl[i].lvl));
      chk($sformatf("tbl%0d in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].rdy});
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d data", i), {32'd0, out_data}, {32'd0, tbl[i].data});
        chk($sformatf("tbl%0d mask", i), {60'd0, out_mask}, {60'd0, tbl[i].mask});
        chk($sformatf("tbl%0d last", i), {63'd0, out_last}, {63'd0, tbl[i].last});
      end
    end

    // Fill to full, overflow attempt, drain in order.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
    chk("full level", {61'd0, fifo_level}, 64'd4);
    chk("full in_ready", {63'd0, in_ready}, 64'd0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("overflow err", {63'd0, err_overflow}, 64'd1);
    chk("first drained word", {32'd0, out_data}, 64'h04030201);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("drained level", {61'd0, fifo_level}, 64'd0);

    // Full with out_ready=1 and in_valid=1: pop only; in_ready returns next cycle.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    chk("full pop level", {61'd0, fifo_level}, 64'd3);
    chk("full pop in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      chk("stream in_ready", {63'd0, in_ready}, 64'd1);
      cyc(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
    end
    chk("stream err", {63'd0, err_overflow}, 64'd0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Clear mid-word, then a clean word.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
    chk("clear out_valid", {63'd0, out_valid}, 64'd0);
    chk("clear level", {61'd0, fifo_level}, 64'd0);
    chk("clear err", {63'd0, err_overflow}, 64'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0, 1'b0);
    chk("post-clear word", {32'd0, out_data}, 64'hA4A3A2A1);
    chk("post-clear mask", {60'd0, out_mask}, 64'hF);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset with two words queued and a partial word.
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("async rst level", {61'd0, fifo_level}, 64'd0);
    chk("async rst in_ready", {63'd0, in_ready}, 64'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h51 + i), 1'b0, 1'b0, 1'b0);
    chk("post-rst word", {32'd0, out_data}, 64'h54535251);
    chk("post-rst level", {61'd0, fifo_level}, 64'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
    end
    model_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
